// File: rtl/xbar_return_arbiter.sv
// rtl/xbar_return_arbiter.sv - per-master return-path (R/B) slave arbiter for the crossbar
//
// Purpose: watches the front entry of every slave-side return FIFO and picks,
// round-robin, one slave whose front entry is addressed to this master. The
// granted slave then pops into this master's return FIFO. With lock_burst=1
// (R channel) the grant is held until a beat with last=1 moves. With
// lock_burst=0 (B channel) the grant is released after every beat.
//
// Ports:
//   ACLK                clock
//   ARESETn             synchronous active-low reset
//   slave_fifo_empty    per-slave return FIFO empty flag
//   slave_dest_master   per-slave destination master of the front entry
//   slave_front_last    per-slave last flag of the front entry
//   master_fifo_full    this master's return FIFO is full
//   grant_slave_number  granted slave index; the value 'slaves' means no grant
//   push_to_fifo        the granted slave's front entry transfers this cycle
//   beat_count          beats moved in the current grant, including this
//                       cycle's beat; saturates at 255
module xbar_return_arbiter #(
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0,
    parameter int lock_burst         = 1,
    localparam int MW = (masters > 1) ? $clog2(masters) : 1,
    localparam int SW = (slaves > 1) ? $clog2(slaves) : 1,
    localparam int GW = $clog2(slaves) + 1
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          slave_fifo_empty  [0:slaves-1],
    input  logic [MW-1:0] slave_dest_master [0:slaves-1],
    input  logic [slaves-1:0] slave_front_last,
    input  logic          master_fifo_full,
    output logic [GW-1:0] grant_slave_number,
    output logic          push_to_fifo,
    output logic [7:0]    beat_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [SW-1:0] gsel_q, gsel_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]  count_q, count_d;

    logic [slaves-1:0] req;
    logic        pick_valid;
    logic [SW-1:0] pick_idx;
    logic [SW:0] cand;
    logic        release_grant;

    for (genvar i = 0; i < slaves; i++) begin : g_req
        assign req[i] = ~slave_fifo_empty[i] &
                        (slave_dest_master[i] == MW'(i_am_master_number));
    end

    // Round-robin pick: scan downwards so the last hit written is the first
    // requester at or after rr_ptr_q (modulo slaves).
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = slaves - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (cand >= (SW+1)'(slaves)) begin
                cand = cand - (SW+1)'(slaves);
            end
            if (req[cand[SW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[SW-1:0];
            end
        end
    end

    // A request that drops mid-burst simply stalls the push; no re-arbitration.
    assign push_to_fifo  = (state_q == GRANT) & req[gsel_q] & ~master_fifo_full;
    assign release_grant = push_to_fifo & ((lock_burst == 0) | slave_front_last[gsel_q]);

    // The sentinel is produced here rather than stored, so gsel_q only ever
    // holds a legal slave index.
    assign grant_slave_number = (state_q == GRANT) ? GW'(gsel_q) : GW'(slaves);
    assign beat_count = (push_to_fifo && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;

    always_comb begin
        state_d  = state_q;
        gsel_d   = gsel_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gsel_d  = pick_idx;
                end
            end
            GRANT: begin
                if (push_to_fifo) begin
                    count_d = beat_count;
                end
                if (release_grant) begin
                    state_d  = IDLE;
                    count_d  = 8'd0;
                    rr_ptr_d = (gsel_q == SW'(slaves - 1)) ? '0 : gsel_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            gsel_q   <= '0;
            rr_ptr_q <= '0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            gsel_q   <= gsel_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_xbar_return_arbiter.sv
// tb/tb_xbar_return_arbiter.sv - directed vector bench for xbar_return_arbiter
module tb_xbar_return_arbiter;

    logic       ACLK;
    logic       ARESETn;
    logic       slave_fifo_empty  [0:1];
    logic [0:0] slave_dest_master [0:1];
    logic [1:0] slave_front_last;
    logic       master_fifo_full;

    logic [1:0] grant_a, grant_b;
    logic       push_a, push_b;
    logic [7:0] beat_a, beat_b;

    int tests_run = 0;
    int tests_failed = 0;

    xbar_return_arbiter #(
        .masters(2), .slaves(2), .i_am_master_number(0), .lock_burst(1)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .slave_fifo_empty(slave_fifo_empty),
        .slave_dest_master(slave_dest_master),
        .slave_front_last(slave_front_last),
        .master_fifo_full(master_fifo_full),
        .grant_slave_number(grant_a),
        .push_to_fifo(push_a),
        .beat_count(beat_a)
    );

    xbar_return_arbiter #(
        .masters(2), .slaves(2), .i_am_master_number(0), .lock_burst(0)
    ) dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .slave_fifo_empty(slave_fifo_empty),
        .slave_dest_master(slave_dest_master),
        .slave_front_last(slave_front_last),
        .master_fifo_full(master_fifo_full),
        .grant_slave_number(grant_b),
        .push_to_fifo(push_b),
        .beat_count(beat_b)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic       rst;
        logic       e0, e1;
        logic       d0, d1;
        logic [1:0] last;
        logic       full;
        int         g, p, b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic e0, input logic e1,
                       input logic d0, input logic d1, input logic [1:0] last,
                       input logic full, input int g, input int p, input int b);
        vec_t v;
        v.rst = rst; v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1;
        v.last = last; v.full = full; v.g = g; v.p = p; v.b = b;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic e0, input logic e1,
                         input logic d0, input logic d1, input logic [1:0] last,
                         input logic full);
        ARESETn              = ~rst;
        slave_fifo_empty[0]  = e0;
        slave_fifo_empty[1]  = e1;
        slave_dest_master[0] = d0;
        slave_dest_master[1] = d1;
        slave_front_last     = last;
        master_fifo_full     = full;
    endtask

    int exp_gb[8];

    initial begin
        // rst e0 e1 d0 d1 last  full   grant push beat
        // reset held three cycles with slave0 requesting
        add(1, 0, 1, 0, 0, 2'b00, 0,  2, 0, 0);
        add(1, 0, 1, 0, 0, 2'b00, 0,  2, 0, 0);
        add(1, 0, 1, 0, 0, 2'b00, 0,  2, 0, 0);
        add(0, 1, 1, 0, 0, 2'b00, 0,  2, 0, 0);
        // slave1 4-beat burst
        add(0, 1, 0, 0, 0, 2'b00, 0,  2, 0, 0);
        add(0, 1, 0, 0, 0, 2'b00, 0,  1, 1, 1);
        add(0, 1, 0, 0, 0, 2'b00, 0,  1, 1, 2);
        add(0, 1, 0, 0, 0, 2'b00, 0,  1, 1, 3);
        add(0, 1, 0, 0, 0, 2'b10, 0,  1, 1, 4);
        add(0, 1, 1, 0, 0, 2'b00, 0,  2, 0, 0);
        // both request: rr_ptr back at 0 -> slave0, then 1, then wrap to 0
        add(0, 0, 0, 0, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 0, 0, 0, 2'b01, 0,  0, 1, 1);
        add(0, 0, 0, 0, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 0, 0, 0, 2'b10, 0,  1, 1, 1);
        add(0, 0, 0, 0, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 0, 0, 0, 2'b00, 0,  0, 1, 1);
        // full stall for 3 cycles, then empty stall, then last beat
        add(0, 0, 0, 0, 0, 2'b00, 1,  0, 0, 1);
        add(0, 0, 0, 0, 0, 2'b00, 1,  0, 0, 1);
        add(0, 0, 0, 0, 0, 2'b00, 1,  0, 0, 1);
        add(0, 0, 0, 0, 0, 2'b00, 0,  0, 1, 2);
        add(0, 1, 0, 0, 0, 2'b00, 0,  0, 0, 2);
        add(0, 1, 0, 0, 0, 2'b00, 0,  0, 0, 2);
        add(0, 0, 0, 0, 0, 2'b01, 0,  0, 1, 3);
        // slave0 addressed to master 1 only: never granted
        add(0, 0, 1, 1, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 1, 1, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 1, 1, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 1, 0, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 1, 0, 0, 2'b00, 0,  0, 1, 1);
        // reset during beat 2; rr_ptr (1 before reset) must restart at 0
        add(1, 0, 1, 0, 0, 2'b00, 0,  0, 1, 2);
        add(0, 0, 0, 0, 0, 2'b00, 0,  2, 0, 0);
        add(0, 0, 0, 0, 0, 2'b00, 0,  0, 1, 1);

        drive(1, 1, 1, 0, 0, 2'b00, 0);
        @(posedge ACLK);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].e0, tbl[i].e1, tbl[i].d0, tbl[i].d1,
                  tbl[i].last, tbl[i].full);
            @(negedge ACLK);
            check($sformatf("row%0d grant", i), int'(grant_a), tbl[i].g);
            check($sformatf("row%0d push", i),  int'(push_a),  tbl[i].p);
            check($sformatf("row%0d beat", i),  int'(beat_a),  tbl[i].b);
            @(posedge ACLK);
            #1;
        end

        // lock_burst=0: single-beat grants alternate with one IDLE cycle between
        drive(1, 1, 1, 0, 0, 2'b00, 0);
        @(posedge ACLK);
        #1;
        exp_gb = '{2, 0, 2, 1, 2, 0, 2, 1};
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 0, 0, 2'b00, 0);
            @(negedge ACLK);
            check($sformatf("b_cyc%0d grant", c), int'(grant_b), exp_gb[c]);
            check($sformatf("b_cyc%0d push", c),  int'(push_b),  c % 2);
            check($sformatf("b_cyc%0d beat", c),  int'(beat_b),  c % 2);
            @(posedge ACLK);
            #1;
        end
        drive(0, 1, 1, 0, 0, 2'b00, 0);
        @(negedge ACLK);
        check("b_drained grant", int'(grant_b), 2);
        check("b_drained push",  int'(push_b),  0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
